// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// State encoding, forwarding selects and latch write-enable vectors.
package hazard_pkg;

   typedef enum logic [2:0] {
      ST_RUN       = 3'd0,
      ST_MISS_I    = 3'd1,
      ST_MISS_D    = 3'd2,
      ST_MISS_BOTH = 3'd3,
      ST_DMA       = 3'd4
   } state_e;

   localparam logic [1:0] FWD_RF  = 2'd0;
   localparam logic [1:0] FWD_EX  = 2'd1;
   localparam logic [1:0] FWD_MEM = 2'd2;
   localparam logic [1:0] FWD_WB  = 2'd3;

   // Bit order {pc, id, ex, m, wb}
   localparam logic [4:0] WE_ALL        = 5'b11111;
   localparam logic [4:0] WE_HOLD_IF_ID = 5'b00111;
   localparam logic [4:0] WE_NONE       = 5'b00000;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// DMA bus request/grant handshake between a DMA master and the hazard unit.
// master = DMA device, slave = hazard unit.
interface pipeline_hazard_unit_if;

   logic br;
   logic dma_done;
   logic bg;
   logic dma_timeout;

   modport master (
      output br,
      output dma_done,
      input  bg,
      input  dma_timeout
   );

   modport slave (
      input  br,
      input  dma_done,
      output bg,
      output dma_timeout
   );

endinterface

// File: rtl/pipeline_hazard_unit_fwd_sel.sv
// Operand forwarding select for one source register.
// Youngest producer wins: EX over MEM over WB, else register file.
module hazard_fwd_sel
   import hazard_pkg::*;
#(
   parameter int W = 2
) (
   input  logic         use_i,
   input  logic [W-1:0] src_i,
   input  logic [W-1:0] ex_dest_i,
   input  logic [W-1:0] m_dest_i,
   input  logic [W-1:0] wb_dest_i,
   input  logic         ex_we_i,
   input  logic         m_we_i,
   input  logic         wb_we_i,
   output logic [1:0]   sel_o
);

   always_comb begin
      sel_o = FWD_RF;
      if (use_i && ex_we_i && src_i == ex_dest_i)
         sel_o = FWD_EX;
      else if (use_i && m_we_i && src_i == m_dest_i)
         sel_o = FWD_MEM;
      else if (use_i && wb_we_i && src_i == wb_dest_i)
         sel_o = FWD_WB;
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// 5-stage hazard controller: forwarding, stalls, miss tracking, DMA grant.
// HAZARD_PERF_CNT_EN adds saturating stall/bubble/dma cycle counters.
module pipeline_hazard_unit
   import hazard_pkg::*;
#(
   parameter int REG_ADDR_W  = 2,
   parameter int DMA_TIMEOUT = 12
`ifdef HAZARD_PERF_CNT_EN
   ,
   parameter int CNT_W       = 16
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_use_rs,
   input  logic                  id_use_rt,
   input  logic                  id_is_halt,
   input  logic [REG_ADDR_W-1:0] ex_dest,
   input  logic [REG_ADDR_W-1:0] m_dest,
   input  logic [REG_ADDR_W-1:0] wb_dest,
   input  logic                  ex_regwrite,
   input  logic                  m_regwrite,
   input  logic                  wb_regwrite,
   input  logic                  ex_is_load,
   input  logic                  i_hit,
   input  logic                  i_ready,
   input  logic                  d_req,
   input  logic                  d_hit,
   input  logic                  d_ready,
   pipeline_hazard_unit_if.slave dma_if,
   output logic                  pc_we,
   output logic                  id_we,
   output logic                  ex_we,
   output logic                  m_we,
   output logic                  wb_we,
   output logic                  flush_ex,
   output logic                  mem_both,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      bubble_cycles,
   output logic [CNT_W-1:0]      dma_cycles
`endif
);

   localparam int CW = (DMA_TIMEOUT < 2) ? 1 : $clog2(DMA_TIMEOUT + 1);
   localparam logic [CW-1:0] TO_MAX  = CW'(DMA_TIMEOUT);
   localparam logic [CW-1:0] TO_LAST = CW'(DMA_TIMEOUT - 1);

   state_e        state_q, state_d;
   logic          bg_q;
   logic          i_done_q, i_done_d;
   logic          d_done_q, d_done_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dmiss, load_use, i_set, d_set;
   logic [4:0]    we;

   hazard_fwd_sel #(.W(REG_ADDR_W)) u_fwd_a (
      .use_i     (id_use_rs),
      .src_i     (id_rs),
      .ex_dest_i (ex_dest),
      .m_dest_i  (m_dest),
      .wb_dest_i (wb_dest),
      .ex_we_i   (ex_regwrite),
      .m_we_i    (m_regwrite),
      .wb_we_i   (wb_regwrite),
      .sel_o     (fwd_a)
   );

   hazard_fwd_sel #(.W(REG_ADDR_W)) u_fwd_b (
      .use_i     (id_use_rt),
      .src_i     (id_rt),
      .ex_dest_i (ex_dest),
      .m_dest_i  (m_dest),
      .wb_dest_i (wb_dest),
      .ex_we_i   (ex_regwrite),
      .m_we_i    (m_regwrite),
      .wb_we_i   (wb_regwrite),
      .sel_o     (fwd_b)
   );

   assign dmiss    = d_req & ~d_hit;
   assign load_use = ex_is_load & (fwd_a == FWD_EX | fwd_b == FWD_EX);
   // Ready pulses count in the cycle they arrive
   assign i_set    = i_done_q | i_ready;
   assign d_set    = d_done_q | d_ready;

   always_comb begin
      state_d  = state_q;
      i_done_d = 1'b0;
      d_done_d = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (dma_if.br && !dmiss)  state_d = ST_DMA;
            else if (dmiss && !i_hit) state_d = ST_MISS_BOTH;
            else if (dmiss)           state_d = ST_MISS_D;
            else if (!i_hit)          state_d = ST_MISS_I;
         end
         ST_MISS_I: begin
            if (dmiss)        state_d = ST_MISS_BOTH;
            else if (i_ready) state_d = ST_RUN;
         end
         ST_MISS_D: begin
            if (d_ready) state_d = i_hit ? ST_RUN : ST_MISS_I;
         end
         ST_MISS_BOTH: begin
            if (i_set && d_set) begin
               state_d = ST_RUN;
            end else begin
               i_done_d = i_set;
               d_done_d = d_set;
            end
         end
         ST_DMA: begin
            if (dma_if.dma_done || !dma_if.br) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      cnt_d = '0;
      if (state_q == ST_DMA && state_d == ST_DMA)
         cnt_d = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_RUN;
         bg_q     <= 1'b0;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         bg_q     <= (state_d == ST_DMA);
         i_done_q <= i_done_d;
         d_done_q <= d_done_d;
         cnt_q    <= cnt_d;
      end
   end

   assign dma_if.bg = bg_q;

   if (DMA_TIMEOUT != 0) begin : g_to
      assign dma_if.dma_timeout = (state_q == ST_DMA) && (cnt_q == TO_LAST);
   end else begin : g_no_to
      assign dma_if.dma_timeout = 1'b0;
   end

   always_comb begin
      we       = WE_ALL;
      flush_ex = 1'b0;
      if (reset) begin
         we       = WE_ALL;
         flush_ex = 1'b0;
      end else if (state_q == ST_MISS_D || state_q == ST_MISS_BOTH ||
                   state_q == ST_DMA || (state_q == ST_RUN && dmiss)) begin
         we       = WE_NONE;
      end else if (state_q == ST_MISS_I ||
                   (state_q == ST_RUN && (!i_hit || load_use || id_is_halt))) begin
         we       = WE_HOLD_IF_ID;
         flush_ex = 1'b1;
      end
   end

   assign {pc_we, id_we, ex_we, m_we, wb_we} = we;
   assign mem_both = !reset && (state_q == ST_MISS_BOTH);

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, bubble_q, dmac_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q  <= '0;
         bubble_q <= '0;
         dmac_q   <= '0;
      end else begin
         if (we == WE_NONE && ~&stall_q)  stall_q  <= stall_q + 1'b1;
         if (flush_ex && ~&bubble_q)      bubble_q <= bubble_q + 1'b1;
         if (bg_q && ~&dmac_q)            dmac_q   <= dmac_q + 1'b1;
      end
   end

   assign stall_cycles  = stall_q;
   assign bubble_cycles = bubble_q;
   assign dma_cycles    = dmac_q;
`endif

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised successor of the 5-stage CPU hazard controller.
- Takes decoded operand, destination and cache status from the datapath. Produces per-latch write enables, ID/EX bubble insertion, operand forwarding selects and DMA bus grant.
- New relative to the previous generation:
  - register-address width is parametrised;
  - I/D miss completion is tracked with latched done flags;
  - DMA bus grant is registered, with a BR/BG handshake and a bounded-hold timeout.
- Branch prediction and BTB update are out of scope and stay in their own block.

Parameters:
- REG_ADDR_W, 2, register-file address width (2^REG_ADDR_W registers).
- DMA_TIMEOUT, 12, maximum DMA hold cycles before dma_timeout pulses; 0 disables the timeout.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs, id_rt  in  REG_ADDR_W  source registers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt.
- id_is_halt  in  1  HLT is in ID.
- ex_dest, m_dest, wb_dest  in  REG_ADDR_W  write-back destination per stage.
- ex_regwrite, m_regwrite, wb_regwrite  in  1  the stage writes the register file.
- ex_is_load  in  1  LWD is in EX.
- i_hit, i_ready  in  1  I-cache hit; referenced I-block ready (1-cycle pulse).
- d_req, d_hit, d_ready  in  1  MEM stage accesses D-cache; D hit; D-block ready (pulse).
- br  in  1  DMA bus request.
- dma_done  in  1  DMA transfer complete (1-cycle pulse).
- bg  out  1  bus grant (registered).
- dma_timeout  out  1  1-cycle pulse when the hold exceeds DMA_TIMEOUT.
- pc_we, id_we, ex_we, m_we, wb_we  out  1  latch write enables.
- flush_ex  out  1  load a bubble into ID/EX.
- mem_both  out  1  I and D misses are both outstanding.
- fwd_a, fwd_b  out  2  forwarding select: 0 RF, 1 EX, 2 MEM, 3 WB.

Behaviour:
- Reset (synchronous): state=RUN, bg=0, i_done=d_done=0, dma_cnt=0, dma_timeout=0.
  - While reset is high, all five enables are 1, flush_ex=0 and mem_both=0.
  - Reset mid-miss or mid-DMA aborts immediately; bg drops on the next edge.
- Forwarding is purely combinational.
  - fwd_a = 1 if id_use_rs && id_rs==ex_dest && ex_regwrite.
  - Otherwise 2 on the same test against the MEM stage, otherwise 3 against WB, otherwise 0.
  - fwd_b uses the identical rule on rt. Priority is EX > MEM > WB.
- load_use = ex_is_load && (fwd_a==1 || fwd_b==1).
- dmiss = d_req && !d_hit.
- States: RUN, MISS_I, MISS_D, MISS_BOTH, DMA. Transitions are checked in the order listed:
  - RUN: br && !dmiss -> DMA. dmiss && !i_hit -> MISS_BOTH. dmiss -> MISS_D. !i_hit -> MISS_I. Otherwise stay.
  - MISS_I: dmiss -> MISS_BOTH. i_ready -> RUN. Otherwise stay.
  - MISS_D: d_ready -> (i_hit ? RUN : MISS_I). Otherwise stay. br is ignored here because the D side owns the bus.
  - MISS_BOTH: i_done/d_done are set by i_ready/d_ready, and a ready pulse in the current cycle counts. Exit to RUN when both are set. Both flags clear on exit.
  - DMA: exit to RUN when dma_done, or when br deasserts. A pending I-miss is re-detected from i_hit in RUN.
- bg is registered: it is 1 in the cycle after entry to DMA and 0 in the cycle after exit, so bg==1 iff state==DMA.
- dma_cnt counts cycles while in DMA and clears on exit.
  - When dma_cnt==DMA_TIMEOUT-1 (only if DMA_TIMEOUT!=0), dma_timeout pulses once.
  - State remains DMA until br drops.
- Enables {pc,id,ex,m,wb} and flush_ex, checked in priority order:
  - MISS_D, MISS_BOTH, DMA, or RUN with dmiss: 00000, flush_ex=0.
  - MISS_I, or RUN with !i_hit: 00111, flush_ex=1.
  - RUN with load_use: 00111, flush_ex=1 (one bubble; the stall clears once the load leaves EX).
  - RUN with id_is_halt: 00111, flush_ex=1 (held indefinitely).
  - Otherwise: 11111, flush_ex=0.
  - On a ready pulse in MISS_D or MISS_BOTH, the exit-cycle enables come from the next-state rules in the following cycle, not the exit cycle; the exit cycle itself stays frozen.
- mem_both = (state==MISS_BOTH).

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds three outputs, stall_cycles, bubble_cycles and dma_cycles, each CNT_W bits.
  - stall_cycles increments when all enables are 0.
  - bubble_cycles increments when flush_ex=1.
  - dma_cycles increments when bg=1.
  - All three saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package hazard_pkg: state encoding (3-bit), FWD_RF/FWD_EX/FWD_MEM/FWD_WB constants (2'd0..3), and the enable-vector constants WE_ALL, WE_HOLD_IF_ID, WE_NONE.
- One sub-module, hazard_fwd_sel: the combinational forwarding mux. It is instantiated twice (rs, rt).

Test Plan:
- Forwarding: id_rs=2 with ex_dest=2/ex_regwrite=1 and m_dest=2/m_regwrite=1 -> fwd_a=1. Drop ex_regwrite -> fwd_a=2. Set id_use_rs=0 -> fwd_a=0.
- Load-use: ex_is_load=1, id_rt=3=ex_dest, id_use_rt=1 -> exactly one cycle of enables 00111 with flush_ex=1, then 11111.
- I-miss: i_hit=0 for 4 cycles, then i_ready -> MISS_I with 00111/flush_ex=1 throughout, RUN the cycle after i_ready.
- Both misses: I-miss, then dmiss, d_ready at +3, i_ready at +6 -> mem_both=1 and 00000 until +6, RUN at +7.
- DMA: br=1 in RUN -> bg=1 next cycle with enables 00000. dma_done at +5 -> bg=0 next cycle. br asserted during MISS_D -> bg stays 0 until d_ready.
- Timeout and reset: DMA_TIMEOUT=4 with br held -> dma_timeout pulses on the 4th DMA cycle, bg stays 1. reset mid-DMA -> bg=0 and enables 11111 the next cycle.
